// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B (mod 2^WIDTH), one full-subtract step per RUN cycle, LSB first.
// Optional signed-overflow flag ovf_o is present only when SERIAL_SUB_OVF_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for start_i; D/BO (and OVF) hold the last result
// S_RUN  | WIDTH cycles, one bit of the difference per cycle
// S_FIN  | one cycle with done_o high; result valid
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] d_o,
    output logic             bo_o
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    // One extra counter bit so WIDTH-1 is always representable, including WIDTH=1.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             diff;
    logic             brw_nxt;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff    = a_q[0] ^ b_q[0] ^ brw_q;
        brw_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    d_d     = '0;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a_i[WIDTH-1];
                    b_msb_d = b_i[WIDTH-1];
`endif
                end
            end
            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                d_d   = (d_q >> 1) | (WIDTH'(diff) << (WIDTH - 1));
                brw_d = brw_nxt;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIN;
`ifdef SERIAL_SUB_OVF_EN
                    // On the last step diff becomes the result MSB.
                    ovf_d = (a_msb_q != b_msb_q) && (diff != a_msb_q);
`endif
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_FIN);
    assign d_o    = d_q;
    // The borrow flop is untouched after the last RUN step, so it holds the final borrow.
    assign bo_o   = brw_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8): directed corner cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    logic [W-1:0] last_d;
    logic         last_bo;
    logic         last_ovf;

    serial_sub #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .a_i     (a_in),
        .b_i     (b_in),
        .busy_o  (busy),
        .done_o  (done),
        .d_o     (d),
        .bo_o    (bo)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf_o   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag);
        chk({tag, ".d"}, 32'(d), 32'(last_d));
        chk({tag, ".bo"}, 32'(bo), 32'(last_bo));
`ifdef SERIAL_SUB_OVF_EN
        chk({tag, ".ovf"}, 32'(ovf), 32'(last_ovf));
`endif
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib, sa, sb, r;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
        sb = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
        r  = sa - sb;
        last_d   = W'((ia - ib + (1 << W)) % (1 << W));
        last_bo  = (ia < ib);
        last_ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endtask

    // Called #1 after a clock edge with the DUT idle. glitch_run pulses START during
    // that RUN cycle (0 = none); glitch_fin pulses START during FIN.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int glitch_run, input bit glitch_fin);
        model(a, b);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        chk("accept.busy", 32'(busy), 32'd1);
        chk("accept.done", 32'(done), 32'd0);
        for (int i = 1; i <= W; i++) begin
            if (i == glitch_run) begin
                start = 1'b1;
                a_in  = ~a;
                b_in  = a;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i < W) begin
                chk("run.done", 32'(done), 32'd0);
                chk("run.busy", 32'(busy), 32'd1);
            end else begin
                chk("fin.done", 32'(done), 32'd1);
                chk("fin.busy", 32'(busy), 32'd1);
                chk_result("fin");
            end
        end
        if (glitch_fin) begin
            start = 1'b1;
            a_in  = b;
            b_in  = a;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("idle.done", 32'(done), 32'd0);
        chk("idle.busy", 32'(busy), 32'd0);
        chk_result("idle");
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #3;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.d", 32'(d), 32'd0);
        chk("rst.bo", 32'(bo), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst.ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed corner cases; consecutive calls are back-to-back (START in the IDLE
        // cycle right after FIN).
        run_op(8'h05, 8'h03, 0, 1'b0);
        run_op(8'h03, 8'h05, 0, 1'b0);
        run_op(8'h00, 8'h01, 0, 1'b0);
        run_op(8'h80, 8'h01, 0, 1'b0);
        run_op(8'h10, 8'h01, 0, 1'b0);
        run_op(8'h7F, 8'hFF, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h00, 8'h00, 0, 1'b0);

        // START re-pulsed in RUN cycle 3 and in FIN must be ignored.
        run_op(8'hA5, 8'h3C, 3, 1'b1);
        @(posedge clk);
        #1;
        chk("glitch.nobusy", 32'(busy), 32'd0);
        chk_result("glitch.hold");

        // Reset in RUN cycle 4 aborts immediately with no DONE.
        start = 1'b1;
        a_in  = 8'h9C;
        b_in  = 8'h21;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.d", 32'(d), 32'd0);
        chk("abort.bo", 32'(bo), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("abort.ovf", 32'(ovf), 32'd0);
`endif
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort.nodone", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        run_op(8'h9C, 8'h21, 0, 1'b0);

        // Random operands with random idle gaps; result must hold while idle.
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
                chk_result("gap.hold");
            end
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
